// File: rtl/idct_block_collector.sv
// idct_block_collector: captures 64-word idct bursts as saturated 8-bit pixels into a ping-pong buffer and streams them out (optional COLLECT_ROUND_EN rounds before extraction)
module idct_block_collector #(
  parameter int BitWidth = 31,
  parameter int FRAC = 10,
  parameter int BLK = 64,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                done,
  input  logic [BitWidth:0]   dout,
  output logic [7:0]          pix_out,
  output logic                pix_valid,
  output logic                pix_last,
  input  logic                pix_ready,
  output logic [CNTW-1:0]     blk_cnt,
  output logic                overflow,
  output logic                short_blk
);
  localparam int W = BitWidth + 1;
  localparam int AW = $clog2(BLK);
  localparam logic [AW-1:0] LAST = AW'(BLK - 1);
  typedef enum logic [1:0] {W_IDLE, W_CAPT, W_WAIT, W_DROP} wst_t;
  typedef enum logic {R_IDLE, R_SEND} rst_t;
  wst_t w_st;
  rst_t r_st;
  logic [7:0] mem [0:2*BLK-1];
  logic [AW-1:0] wr_idx, rd_idx;
  logic [1:0] full;
  logic wb, rb, done_q, go, we, rd_free, wr_free;
  logic [W-1:0] rnd, ip;
  logic [7:0] pix;
`ifdef COLLECT_ROUND_EN
  logic [W:0] sum;
  // add one half LSB of the pixel field, clamping at the positive maximum instead of wrapping
  always_comb begin
    sum = {dout[BitWidth], dout} + (W+1)'(1 << (FRAC - 1));
    rnd = (sum[W] != sum[W-1]) ? {1'b0, {BitWidth{1'b1}}} : sum[W-1:0];
  end
`else
  assign rnd = dout;
`endif
  // saturate the integer part of the fixed-point word to 0..255
  always_comb begin
    ip = rnd >> FRAC;
    pix = rnd[W-1] ? 8'd0 : (|ip[W-1:8]) ? 8'hFF : ip[7:0];
    rd_free = pix_valid & pix_ready & (rd_idx == LAST);
    wr_free = !full[wb] | (rd_free & (rb == wb));
    go = (w_st == W_IDLE) & done & !done_q;
    we = (go & wr_free) | ((w_st == W_CAPT) & done);
  end
  // previous done, so capture only starts on a fresh rise (including after reset)
  always_ff @(posedge clk) done_q <= done;
  // pixel buffer: bank select is the address MSB
  always_ff @(posedge clk) if (we & !reset) mem[{wb, wr_idx}] <= pix;
  // write and read FSMs share the bank-full flags
  always_ff @(posedge clk) begin
    if (reset) begin
      w_st <= W_IDLE;
      r_st <= R_IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      pix_out <= '0;
      pix_valid <= 1'b0;
      pix_last <= 1'b0;
      blk_cnt <= '0;
      overflow <= 1'b0;
      short_blk <= 1'b0;
    end else begin
      if (rd_free) full[rb] <= 1'b0;
      if (we) wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + AW'(1);
      case (w_st)
        W_IDLE: if (go) begin
          w_st <= wr_free ? W_CAPT : W_DROP;
          if (!wr_free) overflow <= 1'b1;
        end
        W_CAPT: if (!done) begin
          short_blk <= 1'b1;
          wr_idx <= '0;
          w_st <= W_IDLE;
        end else if (wr_idx == LAST) begin
          full[wb] <= 1'b1;
          blk_cnt <= blk_cnt + CNTW'(1);
          wb <= ~wb;
          w_st <= W_WAIT;
        end
        W_WAIT, W_DROP: if (!done) w_st <= W_IDLE;
      endcase
      if (r_st == R_IDLE) begin
        if (full[rb]) begin
          r_st <= R_SEND;
          pix_valid <= 1'b1;
          pix_last <= 1'b0;
          pix_out <= mem[{rb, rd_idx}];
        end
      end else if (pix_ready) begin
        if (rd_idx == LAST) begin
          r_st <= R_IDLE;
          pix_valid <= 1'b0;
          pix_last <= 1'b0;
          rd_idx <= '0;
          rb <= ~rb;
        end else begin
          rd_idx <= rd_idx + AW'(1);
          pix_out <= mem[{rb, rd_idx + AW'(1)}];
          pix_last <= (rd_idx + AW'(1)) == LAST;
        end
      end
    end
  end
endmodule

// File: tb/tb_idct_block_collector.sv
// tb_idct_block_collector: directed bursts with hand-computed pixels for idct_block_collector
module tb_idct_block_collector;
  logic clk = 0, reset = 1, done = 0, pix_ready = 0;
  logic [31:0] dout = 0;
  logic [7:0] pix_out;
  logic pix_valid, pix_last, overflow, short_blk;
  logic [15:0] blk_cnt;
  int n_run = 0, n_fail = 0, ready_mode = 0;
  logic [7:0] got_pix[$];
  logic got_last[$];
  logic [31:0] wv [64];
  logic [7:0] ev [64];
  logic stall = 0;
  logic [7:0] held = 0;

  always #5 clk = ~clk;

  idct_block_collector dut (
    .clk(clk), .reset(reset), .done(done), .dout(dout),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
    .blk_cnt(blk_cnt), .overflow(overflow), .short_blk(short_blk)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      done = 1;
      dout = wv[i];
      tick(1);
    end
    done = 0;
    dout = 0;
    tick(1);
  endtask

  task automatic wait_pix(input string tag, input int n);
    int k = 0;
    while (got_pix.size() < n && k < 4000) begin
      tick(1);
      k++;
    end
    chk(tag, got_pix.size(), n);
  endtask

  task automatic cmp_blk(input string tag, input int off);
    for (int i = 0; i < 64; i++) begin
      chk(tag, got_pix[off+i], ev[i]);
      chk({tag, "_last"}, got_last[off+i], i == 63);
    end
  endtask

  task automatic clr();
    got_pix.delete();
    got_last.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"}, pix_out, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_last"}, pix_last, 0);
    chk({tag, "_cnt"}, blk_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_short"}, short_blk, 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  always @(negedge clk) begin
    if (stall && pix_valid) chk("hold", pix_out, held);
    if (pix_valid && pix_ready) begin
      got_pix.push_back(pix_out);
      got_last.push_back(pix_last);
    end
    stall = pix_valid && !pix_ready;
    held = pix_out;
  end

  initial begin
    reset = 1;
    tick(3);
    chk_zero("rst");
    reset = 0;
    tick(2);
    ready_mode = 1;
    for (int i = 0; i < 64; i++) begin wv[i] = i << 10; ev[i] = 8'(i); end
    burst(64);
    wait_pix("b1_n", 64);
    cmp_blk("b1", 0);
    chk("b1_cnt", blk_cnt, 1);
    clr();
    for (int i = 0; i < 64; i++) begin wv[i] = i << 10; ev[i] = 8'(i); end
    wv[0] = 32'hFFFF_EC00; ev[0] = 0;
    wv[1] = 300 << 10;     ev[1] = 255;
    wv[2] = 128 << 10;     ev[2] = 128;
    wv[3] = 32'h0000_01FF; ev[3] = 0;
`ifdef COLLECT_ROUND_EN
    wv[4] = 32'h0000_0200; ev[4] = 1;
`else
    wv[4] = 32'h0000_0200; ev[4] = 0;
`endif
    wv[5] = 32'h7FFF_FFFF; ev[5] = 255;
    wv[6] = 32'h0003_FFFF; ev[6] = 255;
    wv[7] = 32'h8000_0000; ev[7] = 0;
    burst(64);
    wait_pix("clamp_n", 64);
    cmp_blk("clamp", 0);
    chk("clamp_cnt", blk_cnt, 2);
    clr();
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 64; i++) wv[i] = (i + 1) << 10;
    burst(64);
    for (int i = 0; i < 64; i++) wv[i] = (i + 100) << 10;
    burst(64);
    for (int i = 0; i < 64; i++) wv[i] = (i + 200) << 10;
    burst(64);
    tick(3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", blk_cnt, 4);
    chk("ovf_valid", pix_valid, 1);
    chk("ovf_first", pix_out, 1);
    chk("ovf_short", short_blk, 0);
    chk("ovf_none", got_pix.size(), 0);
    ready_mode = 1;
    wait_pix("ovf_n", 128);
    for (int i = 0; i < 64; i++) ev[i] = 8'(i + 1);
    cmp_blk("ovf_a", 0);
    for (int i = 0; i < 64; i++) ev[i] = 8'(i + 100);
    cmp_blk("ovf_b", 64);
    tick(100);
    chk("ovf_drop_n", got_pix.size(), 128);
    chk("ovf_idle", pix_valid, 0);
    clr();
    for (int i = 0; i < 64; i++) wv[i] = (i + 50) << 10;
    burst(40);
    tick(5);
    chk("short_flag", short_blk, 1);
    chk("short_valid", pix_valid, 0);
    chk("short_cnt", blk_cnt, 4);
    chk("short_none", got_pix.size(), 0);
    for (int i = 0; i < 64; i++) begin wv[i] = (i + 7) << 10; ev[i] = 8'(i + 7); end
    burst(64);
    wait_pix("after_short_n", 64);
    cmp_blk("after_short", 0);
    chk("after_short_cnt", blk_cnt, 5);
    clr();
    ready_mode = 2;
    for (int i = 0; i < 64; i++) begin wv[i] = (63 - i) << 10; ev[i] = 8'(63 - i); end
    burst(64);
    wait_pix("rand_n", 64);
    cmp_blk("rand", 0);
    ready_mode = 1;
    tick(5);
    chk("rand_dup", got_pix.size(), 64);
    chk("rand_cnt", blk_cnt, 6);
    clr();
    for (int i = 0; i < 64; i++) wv[i] = (i + 9) << 10;
    for (int i = 0; i < 30; i++) begin
      done = 1;
      dout = wv[i];
      tick(1);
    end
    reset = 1;
    tick(2);
    chk_zero("midrst");
    reset = 0;
    tick(10);
    done = 0;
    tick(5);
    chk_zero("postrst");
    chk("postrst_none", got_pix.size(), 0);
    for (int i = 0; i < 64; i++) begin wv[i] = (i + 20) << 10; ev[i] = 8'(i + 20); end
    burst(64);
    wait_pix("resume_n", 64);
    cmp_blk("resume", 0);
    chk("resume_cnt", blk_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
